// File: rtl/feeder_pkg.sv
// Shared types and constants for the operand feeder.
// FSM encodings, FIFO depth and LFSR tap/seed constants.
package feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    WRITE  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int FIFO_DEPTH = 4;

  // x^16+x^14+x^13+x^11+1 -> q[15],q[13],q[12],q[10]
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/lfsr16_module.sv
// 16-bit Fibonacci LFSR with synchronous seed load.
// Only instantiated when FEEDER_LFSR_EN is defined.
module lfsr16_module
  import feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED_DEF;
    end else if (load) begin
      q <= seed;
    end else if (advance) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/operand_feeder_module.sv
// Operand pair generator feeding the multiplier operand FIFO.
// Define FEEDER_LFSR_EN to source pairs from a 16-bit LFSR.
module operand_feeder_module
  import feeder_pkg::*;
#(
  parameter int unsigned PAIR_COUNT = 16,
  parameter logic [7:0]  A_INIT     = 8'd1,
  parameter logic [7:0]  B_INIT     = 8'd1,
  parameter logic [7:0]  A_STEP     = 8'd1,
  parameter logic [7:0]  B_STEP     = 8'd3
`ifdef FEEDER_LFSR_EN
  ,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_sig,
  input  logic [2:0]  left_sig,
  output logic        write_req,
  output logic [15:0] fifo_write_data,
  output logic        busy,
  output logic        done_sig
);

  localparam logic [7:0] LAST = 8'(PAIR_COUNT);

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [7:0]  a, a_nxt;
  logic [7:0]  b, b_nxt;
  logic        write_req_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [15:0] data_nxt;
  logic [15:0] pair;

`ifdef FEEDER_LFSR_EN
  logic [15:0] lfsr_q;

  lfsr16_module u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == IDLE && start_sig),
    .advance (state == WRITE),
    .seed    (LFSR_SEED),
    .q       (lfsr_q)
  );

  assign pair = lfsr_q;
`else
  assign pair = {a, b};
`endif

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    a_nxt         = a;
    b_nxt         = b;
    write_req_nxt = 1'b0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    data_nxt      = fifo_write_data;
    unique case (state)
      IDLE: begin
        if (start_sig) begin
          a_nxt     = A_INIT;
          b_nxt     = B_INIT;
          count_nxt = 8'd0;
          busy_nxt  = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (left_sig != 3'd0) begin
          write_req_nxt = 1'b1;
          data_nxt      = pair;
          state_nxt     = WRITE;
        end
      end
      WRITE: begin
        a_nxt     = a + A_STEP;
        b_nxt     = b + B_STEP;
        count_nxt = count + 8'd1;
        state_nxt = SETTLE;
      end
      // dead cycle: left_sig is not trusted right after a write
      SETTLE: begin
        if (count == LAST) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = CHECK;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= 8'd0;
      a               <= 8'd0;
      b               <= 8'd0;
      write_req       <= 1'b0;
      fifo_write_data <= 16'h0000;
      busy            <= 1'b0;
      done_sig        <= 1'b0;
    end else begin
      state           <= state_nxt;
      count           <= count_nxt;
      a               <= a_nxt;
      b               <= b_nxt;
      write_req       <= write_req_nxt;
      fifo_write_data <= data_nxt;
      busy            <= busy_nxt;
      done_sig        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_operand_feeder_module.sv
// Directed bench for operand_feeder_module (default and wrap configs).
// Expected data follows the LFSR sequence when FEEDER_LFSR_EN is defined.
module tb_operand_feeder_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_sig;
  logic [2:0]  left_sig;
  logic        write_req, write_req2;
  logic [15:0] data, data2;
  logic        busy, busy2;
  logic        done_sig, done_sig2;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  operand_feeder_module dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_sig       (start_sig),
    .left_sig        (left_sig),
    .write_req       (write_req),
    .fifo_write_data (data),
    .busy            (busy),
    .done_sig        (done_sig)
  );

  operand_feeder_module #(
    .PAIR_COUNT (3),
    .A_INIT     (8'hFE),
    .A_STEP     (8'd1),
    .B_INIT     (8'hFF),
    .B_STEP     (8'd2)
  ) dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_sig       (start_sig),
    .left_sig        (left_sig),
    .write_req       (write_req2),
    .fifo_write_data (data2),
    .busy            (busy2),
    .done_sig        (done_sig2)
  );

  always @(posedge clk) begin
    if (write_req) wr_cnt++;
    if (done_sig) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_def(input int i);
    logic [15:0] q;
`ifdef FEEDER_LFSR_EN
    q = 16'hACE1;
    for (int j = 0; j < i; j++)
      q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
`else
    q = {8'(1 + i), 8'(1 + 3 * i)};
`endif
    return q;
  endfunction

  function automatic logic [15:0] exp_wrap(input int i);
    logic [15:0] tbl [3];
    tbl = '{16'hFEFF, 16'hFF01, 16'h0003};
`ifdef FEEDER_LFSR_EN
    return exp_def(i);
`else
    return tbl[i];
`endif
  endfunction

  initial begin
    logic found;
    rst_n     = 1'b0;
    start_sig = 1'b0;
    left_sig  = 3'd4;
    tick();
    tick();
    chk("rst_wr", {15'd0, write_req}, 16'd0);
    chk("rst_data", data, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done_sig}, 16'd0);
    rst_n = 1'b1;
    tick();

    // burst with free FIFO; both configs run together
`ifdef FEEDER_LFSR_EN
    chk("lfsr_hand0", exp_def(0), 16'hACE1);
    chk("lfsr_hand1", exp_def(1), 16'h59C3);
`else
    chk("hand2", exp_def(2), 16'h0307);
`endif
    wr_cnt    = 0;
    done_cnt  = 0;
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    chk("start_busy", {15'd0, busy}, 16'd1);
    chk("start_wr", {15'd0, write_req}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("wr_hi%0d", i), {15'd0, write_req}, 16'd1);
      chk($sformatf("data%0d", i), data, exp_def(i));
      if (i < 3) begin
        chk($sformatf("w2_hi%0d", i), {15'd0, write_req2}, 16'd1);
        chk($sformatf("w2_data%0d", i), data2, exp_wrap(i));
      end
      tick();
      chk($sformatf("wr_lo%0d", i), {15'd0, write_req}, 16'd0);
      chk($sformatf("hold%0d", i), data, exp_def(i));
      tick();
      chk($sformatf("done%0d", i), {15'd0, done_sig},
          (i == 15) ? 16'd1 : 16'd0);
      if (i == 2)
        chk("w2_done", {15'd0, done_sig2}, 16'd1);
      if (i == 3)
        chk("w2_idle", {15'd0, busy2}, 16'd0);
    end
    chk("done_busy", {15'd0, busy}, 16'd1);
    tick();
    chk("done_fall", {15'd0, done_sig}, 16'd0);
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("burst_wr_cnt", 16'(wr_cnt), 16'd16);

    // stall: no free slots for 10 cycles
    left_sig  = 3'd0;
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("stall_wr%0d", c), {15'd0, write_req}, 16'd0);
      chk($sformatf("stall_busy%0d", c), {15'd0, busy}, 16'd1);
    end
    left_sig = 3'd4;
    tick();
    chk("unstall_wr", {15'd0, write_req}, 16'd1);
    chk("unstall_data", data, exp_def(0));
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (done_sig) found = 1'b1;
    end
    chk("stall_done", {15'd0, found}, 16'd1);
    tick();

    // start re-pulsed mid-burst and together with done_sig
    wr_cnt    = 0;
    done_cnt  = 0;
    start_sig = 1'b1;
    tick();
    for (int c = 1; c <= 60; c++) begin
      start_sig = (c == 7 || c == 20 || c == 49);
      tick();
    end
    start_sig = 1'b0;
    chk("restart_wr_cnt", 16'(wr_cnt), 16'd16);
    chk("restart_done_cnt", 16'(done_cnt), 16'd1);
    chk("restart_busy", {15'd0, busy}, 16'd0);

    // async reset during the 5th WRITE state
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    for (int c = 0; c < 13; c++) tick();
    chk("pre_rst_wr", {15'd0, write_req}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", {15'd0, write_req}, 16'd0);
    chk("arst_data", data, 16'h0000);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_done", {15'd0, done_sig}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {15'd0, busy}, 16'd0);
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    tick();
    chk("new_wr", {15'd0, write_req}, 16'd1);
    chk("new_data", data, exp_def(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
